// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline-stage registers: stage occupancy
// encoding, default stall-counter width and per-boundary payload widths.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } stage_state_e;

   localparam int DEF_CNT_W = 16;

   // Payload widths used at each classic pipeline boundary
   localparam int IF_ID_W  = 64;
   localparam int ID_EX_W  = 128;
   localparam int EX_MEM_W = 128;
   localparam int MEM_WB_W = 96;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clr wins.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk) begin
      if (clr) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with optional two-entry skid buffer,
// synchronous flush and a saturating downstream-stall counter.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W     = 64,
   parameter logic [DATA_W-1:0] RESET_DATA = '0,
   parameter bit                SKID_EN    = 1'b1,
   parameter int                CNT_W      = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   stage_state_e      state_d, state_q;
   logic [DATA_W-1:0] main_d, main_q;
   logic [DATA_W-1:0] skid_d, skid_q;

   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = out_valid ? main_q : RESET_DATA;

   // With the skid buffer, in_ready is purely a decode of the state register
   generate
      if (SKID_EN) begin : g_ready_reg
         assign in_ready = (state_q != ST_SKID);
      end else begin : g_ready_comb
         assign in_ready = !out_valid || out_ready;
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_valid) begin
               main_d  = in_data;
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (out_ready) begin
               if (in_valid) main_d  = in_data;
               else          state_d = ST_EMPTY;
            end else if (in_valid && SKID_EN) begin
               skid_d  = in_data;
               state_d = ST_SKID;
            end
         end
         ST_SKID: begin
            // Main drains first; skid entry moves up to preserve order
            if (out_ready) begin
               main_d  = skid_q;
               state_d = ST_FULL;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = RESET_DATA;
         skid_d  = RESET_DATA;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         main_q  <= RESET_DATA;
         skid_q  <= RESET_DATA;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .clr (reset),
      .inc (out_valid && !out_ready),
      .cnt (stall_cnt)
   );

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline-stage register: the successor to the fixed IF/ID latch, for use between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an arbitrary-width payload with a valid/ready handshake in place of a bare stall input.
- Optional 2-entry skid buffer so the upstream ready is fully registered.
- Synchronous flush that inserts a bubble.
- Saturating stall-cycle counter for performance debug.

Parameters:
DATA_W, 64, payload width in bits (e.g. PC plus instruction).
RESET_DATA, 0, value driven on out_data whenever out_valid=0; also the value main/skid registers take on reset or flush.
SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
CNT_W, 16, width of stall_cnt.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high; highest priority
flush  in  1  synchronous; empties the stage, takes effect at the next edge
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept at this edge
in_data  in  DATA_W  upstream payload
out_valid  out  1  stage holds a valid payload
out_ready  in  1  downstream accepts at this edge (low = stall)
out_data  out  DATA_W  payload; equals RESET_DATA when out_valid=0
stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Handshakes: transfer in when in_valid&&in_ready at the edge; transfer out when out_valid&&out_ready at the edge. Once out_valid is high, it and out_data stay stable until transfer or flush.
- Reset values: state=EMPTY, out_valid=0, out_data=RESET_DATA, main=skid=RESET_DATA, stall_cnt=0. in_ready=1 during and after reset.
- Latency: 1 cycle from in-transfer to out_valid. Throughput: 1 per cycle when out_ready is held high.
- States: EMPTY (0 entries), FULL (main valid), SKID (main and skid valid).
- EMPTY: out_valid=0, in_ready=1.
  - in_valid -> main<=in_data, go to FULL.
- FULL: out_valid=1, in_ready=1 (SKID_EN=1) or in_ready=out_ready (SKID_EN=0).
  - in_valid&&out_ready -> main<=in_data, stay FULL.
  - !in_valid&&out_ready -> go to EMPTY.
  - in_valid&&!out_ready -> skid<=in_data, go to SKID (SKID_EN=1 only).
  - !in_valid&&!out_ready -> hold.
- SKID: out_valid=1, in_ready=0.
  - out_ready -> main<=skid, go to FULL.
  - else hold.
  - Order is preserved: main drains before skid.
- SKID_EN=0: SKID state is unreachable. in_ready = !out_valid || out_ready.
- flush (no reset): next state EMPTY, main=skid=RESET_DATA.
  - Any in-transfer in the same cycle is discarded.
  - A same-cycle out-transfer still counts as accepted downstream.
  - stall_cnt is NOT cleared.
- reset overrides flush and all handshakes, and aborts mid-operation from any state.
- stall_cnt: +1 per cycle with out_valid&&!out_ready; saturates at 2^CNT_W-1 (no wrap). Cleared only by reset.
- No combinational path from in_valid/in_data to the outputs. With SKID_EN=1, in_ready is a registered state decode.

Decomposition:
- Shared package pipe_pkg holds:
  - stage-state enum (ST_EMPTY, ST_FULL, ST_SKID);
  - default CNT_W;
  - per-stage payload width constants (IF_ID_W=64 etc.).
- One sub-module, sat_counter (width param; inc, clr inputs; saturating), instantiated for stall_cnt.
- Datapath and FSM stay in pipe_stage_reg.

Test Plan:
- Reset then stream with out_ready=1: in_data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each; in_ready stays 1; stall_cnt=0.
- SKID_EN=1, out_ready=0 from cycle 2: send 0xA,0xB,0xC -> state SKID, in_ready=0 after 0xB, 0xC not accepted; release out_ready -> out 0xA,0xB, then 0xC. stall_cnt equals the number of stalled cycles with out_valid=1.
- SKID_EN=0, same stimulus -> in_ready=0 while out_valid&&!out_ready; no data loss; order 0xA,0xB,0xC.
- Flush in FULL with in_valid=1 (0x55): next cycle out_valid=0, out_data=RESET_DATA, 0x55 dropped. Flush in SKID -> both entries dropped, in_ready=1.
- CNT_W=4, hold a stall for 20 cycles -> stall_cnt=15 and holds. Flush -> stays 15. Reset -> 0.
- Reset asserted mid-SKID together with flush and in_valid -> next edge EMPTY, out_valid=0, stall_cnt=0, in_ready=1.
